// File: rtl/if_id_ctrl.sv
// IF/ID pipeline control: PC register, IF/ID latch, RUN/STALL/FLUSH FSM and stall watchdog.
// Optional `define IF_ID_PERF_CNT_EN adds saturating stall/flush cycle counters.
module if_id_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned STALL_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCwrite,
  input  logic        IF_IDwrite,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  input  logic [31:0] instrIn,
  output logic [31:0] PC,
  output logic [31:0] IF_IDpc,
  output logic [31:0] IF_IDinstr,
  output logic        IF_IDvalid,
  output logic        ID_EXflush,
  output logic [1:0]  state,
`ifdef IF_ID_PERF_CNT_EN
  output logic [31:0] stallCycles,
  output logic [31:0] flushCycles,
`endif
  output logic        stallErr
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } state_t;

  localparam int CW = $clog2(STALL_MAX + 1);
  localparam logic [CW-1:0] STALL_LIM = CW'(STALL_MAX);

  state_t        r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_ifid_pc;
  logic [31:0]   r_ifid_instr;
  logic          r_ifid_valid;
  logic [CW-1:0] r_stall_cnt;
  logic          r_stall_err;

  logic          w_pc_en;
  logic          w_ifid_en;
  state_t        w_next_state;
  logic [CW-1:0] w_stall_inc;

  // A flushed slot holds a NOP whose rs=x0 could falsely match a load-use hazard.
  assign w_pc_en   = PCwrite    || (r_state == FLUSH);
  assign w_ifid_en = IF_IDwrite || (r_state == FLUSH);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = RUN;
    w_stall_inc  = r_stall_cnt;
    if (branchTaken)   w_next_state = FLUSH;
    else if (!w_pc_en) w_next_state = STALL;
    if (r_stall_cnt != STALL_LIM) w_stall_inc = r_stall_cnt + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RUN;
      r_pc         <= RESET_PC;
      r_ifid_pc    <= RESET_PC;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
      r_stall_cnt  <= '0;
      r_stall_err  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (branchTaken) begin
        r_pc         <= {branchTarget[31:2], 2'b00};
        r_ifid_instr <= NOP_INSTR;
        r_ifid_valid <= 1'b0;
      end else begin
        if (w_pc_en) r_pc <= r_pc + 32'd4;
        if (w_ifid_en) begin
          r_ifid_pc    <= r_pc;
          r_ifid_instr <= instrIn;
          r_ifid_valid <= 1'b1;
        end
      end
      if (r_state == STALL && w_next_state == STALL) r_stall_cnt <= w_stall_inc;
      else                                           r_stall_cnt <= '0;
      if (r_state == STALL && w_stall_inc == STALL_LIM) r_stall_err <= 1'b1;
    end
  end

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_cycles <= '0;
    end else begin
      if (r_state == STALL && r_stall_cycles != 32'hFFFF_FFFF) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (r_state == FLUSH && r_flush_cycles != 32'hFFFF_FFFF) r_flush_cycles <= r_flush_cycles + 32'd1;
    end
  end

  assign stallCycles = r_stall_cycles;
  assign flushCycles = r_flush_cycles;
`endif

  assign PC         = r_pc;
  assign IF_IDpc    = r_ifid_pc;
  assign IF_IDinstr = r_ifid_instr;
  assign IF_IDvalid = r_ifid_valid;
  assign ID_EXflush = branchTaken;
  assign state      = r_state;
  assign stallErr   = r_stall_err;

endmodule

// File: tb/tb_if_id_ctrl.sv
// Directed bench for if_id_ctrl: reset, load-use stall, branch over stall, flush ignore, watchdog, PC wrap.
module tb_if_id_ctrl;

  logic        clk = 1'b0;
  logic        rst, PCwrite, IF_IDwrite, branchTaken;
  logic [31:0] branchTarget, instrIn;
  logic [31:0] PC, IF_IDpc, IF_IDinstr;
  logic        IF_IDvalid, ID_EXflush, stallErr;
  logic [1:0]  state;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stallCycles, flushCycles;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  if_id_ctrl dut (
    .clk(clk), .rst(rst), .PCwrite(PCwrite), .IF_IDwrite(IF_IDwrite),
    .branchTaken(branchTaken), .branchTarget(branchTarget), .instrIn(instrIn),
    .PC(PC), .IF_IDpc(IF_IDpc), .IF_IDinstr(IF_IDinstr), .IF_IDvalid(IF_IDvalid),
    .ID_EXflush(ID_EXflush), .state(state),
`ifdef IF_ID_PERF_CNT_EN
    .stallCycles(stallCycles), .flushCycles(flushCycles),
`endif
    .stallErr(stallErr)
  );

  always #5 clk = ~clk;

  // Instruction memory stand-in: a distinct, recognisable word per address.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0], 16'hC0DE};
  endfunction

  assign instrIn = imem(PC);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] ipc,
                            input logic [31:0] instr, input logic valid, input logic [1:0] st);
    check({tag, ".PC"},         PC,         pc);
    check({tag, ".IF_IDpc"},    IF_IDpc,    ipc);
    check({tag, ".IF_IDinstr"}, IF_IDinstr, instr);
    check({tag, ".IF_IDvalid"}, 32'(IF_IDvalid), 32'(valid));
    check({tag, ".state"},      32'(state), 32'(st));
  endtask

  initial begin
    rst = 1'b1; PCwrite = 1'b1; IF_IDwrite = 1'b1; branchTaken = 1'b0; branchTarget = '0;
    step(); step();
    check_ifid("reset", 32'h0, 32'h0, 32'h13, 1'b0, 2'b00);
    check("reset.stallErr", 32'(stallErr), 32'd0);
`ifdef IF_ID_PERF_CNT_EN
    check("reset.stallCycles", stallCycles, 32'd0);
    check("reset.flushCycles", flushCycles, 32'd0);
`endif

    // First fetch from RESET_PC, then sequential advance.
    rst = 1'b0;
    check("run0.PC", PC, 32'h0);
    step();
    check_ifid("run1", 32'h4, 32'h0, imem(32'h0), 1'b1, 2'b00);
    step();
    check_ifid("run2", 32'h8, 32'h4, imem(32'h4), 1'b1, 2'b00);
    step(); step();
    check_ifid("run4", 32'h10, 32'hC, imem(32'hC), 1'b1, 2'b00);

    // One-cycle load-use stall at PC=0x10.
    PCwrite = 1'b0; IF_IDwrite = 1'b0;
    step();
    check_ifid("stall", 32'h10, 32'hC, imem(32'hC), 1'b1, 2'b01);
    PCwrite = 1'b1; IF_IDwrite = 1'b1;
    step();
    check_ifid("unstall", 32'h14, 32'h10, imem(32'h10), 1'b1, 2'b00);

    // Branch overrides a concurrent stall request; target is word-aligned.
    branchTaken = 1'b1; branchTarget = 32'h203; PCwrite = 1'b0; IF_IDwrite = 1'b0;
    #1 check("br.ID_EXflush_comb", 32'(ID_EXflush), 32'd1);
    step();
    check_ifid("br", 32'h200, 32'h10, 32'h13, 1'b0, 2'b10);

    // In FLUSH, stall requests are ignored.
    branchTaken = 1'b0;
    #1 check("flush.ID_EXflush_comb", 32'(ID_EXflush), 32'd0);
    step();
    check_ifid("flush_ign", 32'h204, 32'h200, imem(32'h200), 1'b1, 2'b00);

    // STALL -> FLUSH -> FLUSH (back-to-back branches), then wrap past 0xFFFFFFFC.
    step();
    check_ifid("stall2", 32'h204, 32'h200, imem(32'h200), 1'b1, 2'b01);
    branchTaken = 1'b1; branchTarget = 32'h300;
    step();
    check_ifid("br_from_stall", 32'h300, 32'h200, 32'h13, 1'b0, 2'b10);
    branchTarget = 32'hFFFF_FFFF;
    step();
    check_ifid("br_in_flush", 32'hFFFF_FFFC, 32'h200, 32'h13, 1'b0, 2'b10);
    branchTaken = 1'b0; PCwrite = 1'b1; IF_IDwrite = 1'b1;
    step();
    check_ifid("wrap", 32'h0, 32'hFFFF_FFFC, imem(32'hFFFF_FFFC), 1'b1, 2'b00);
`ifdef IF_ID_PERF_CNT_EN
    check("mix.stallCycles", stallCycles, 32'd2);
    check("mix.flushCycles", flushCycles, 32'd3);
`endif

    // IF/ID held while the PC still advances.
    IF_IDwrite = 1'b0;
    step();
    check_ifid("ifid_hold", 32'h4, 32'hFFFF_FFFC, imem(32'hFFFF_FFFC), 1'b1, 2'b00);

    // Watchdog: fresh reset, then PCwrite=0 for 16 cycles.
    rst = 1'b1; IF_IDwrite = 1'b1;
    step();
    check_ifid("rst2", 32'h0, 32'h0, 32'h13, 1'b0, 2'b00);
`ifdef IF_ID_PERF_CNT_EN
    check("rst2.flushCycles", flushCycles, 32'd0);
`endif
    rst = 1'b0;
    step();
    check("wd.start_PC", PC, 32'h4);
    PCwrite = 1'b0; IF_IDwrite = 1'b0;
    for (int i = 0; i < 15; i++) step();
    check("wd.15.stallErr", 32'(stallErr), 32'd0);
    check("wd.15.state", 32'(state), 32'd1);
    step();
    check("wd.16.PC", PC, 32'h4);
    PCwrite = 1'b1; IF_IDwrite = 1'b1;
    step();
    check("wd.end.stallErr", 32'(stallErr), 32'd1);
    check("wd.end.state", 32'(state), 32'd0);
    check("wd.end.PC", PC, 32'h8);
`ifdef IF_ID_PERF_CNT_EN
    check("wd.stallCycles", stallCycles, 32'd16);
`endif
    step(); step();
    check("wd.sticky.stallErr", 32'(stallErr), 32'd1);

    // Reset mid-stall overrides a simultaneous branch and clears the sticky error.
    PCwrite = 1'b0;
    step();
    check("pre_rst.state", 32'(state), 32'd1);
    rst = 1'b1; branchTaken = 1'b1; branchTarget = 32'h400;
    step();
    check_ifid("rst_mid", 32'h0, 32'h0, 32'h13, 1'b0, 2'b00);
    check("rst_mid.stallErr", 32'(stallErr), 32'd0);
`ifdef IF_ID_PERF_CNT_EN
    check("rst_mid.stallCycles", stallCycles, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_id_ctrl.md
IF_ID_CTRL -- requirements
Module: if_id_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000: PC value loaded at reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h00000013: the addi x0,x0,0 encoding inserted on flush.
REQ-003 SHALL have parameter STALL_MAX, default 16: consecutive-stall limit before a watchdog error.
REQ-004 SHALL have ports: clk  in  1  rising-edge clock; one clock domain only.
REQ-005 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports: PCwrite  in  1  hazard-unit PC enable; 0 requests a stall.
REQ-007 SHALL have ports: IF_IDwrite  in  1  hazard-unit IF/ID enable; 0 holds the register.
REQ-008 SHALL have ports: branchTaken  in  1  taken branch/jump resolved in EX.
REQ-009 SHALL have ports: branchTarget  in  32  redirect address.
REQ-010 SHALL have ports: instrIn  in  32  instruction-memory data for the current PC (combinational read).
REQ-011 SHALL have ports: PC  out  32  fetch address.
REQ-012 SHALL have ports: IF_IDpc  out  32  PC of the instruction held in IF/ID.
REQ-013 SHALL have ports: IF_IDinstr  out  32  instruction held in IF/ID.
REQ-014 SHALL have ports: IF_IDvalid  out  1  IF/ID holds a real instruction, not an inserted NOP.
REQ-015 SHALL have ports: ID_EXflush  out  1  combinational equal to branchTaken; zeroes ID/EX controls.
REQ-016 SHALL have ports: state  out  2  FSM state: 00 RUN, 01 STALL, 10 FLUSH.
REQ-017 SHALL have ports: stallErr  out  1  sticky watchdog error.

Function
REQ-018 Priority each edge SHALL be: rst, then branchTaken, then stall (PCwrite/IF_IDwrite), then normal advance.
REQ-019 On branchTaken: PC SHALL load {branchTarget[31:2],2'b00}; IF_IDinstr SHALL load NOP_INSTR; IF_IDvalid SHALL be 0; IF_IDpc SHALL hold; next state SHALL be FLUSH. This applies even when PCwrite=0.
REQ-020 When PCwrite=1 with no branch: PC SHALL advance to PC+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000). When PCwrite=0: PC SHALL hold.
REQ-021 When IF_IDwrite=1 with no branch: IF_IDinstr SHALL load instrIn, IF_IDpc SHALL load PC, and IF_IDvalid SHALL be 1. When IF_IDwrite=0: all IF/ID outputs SHALL hold.
REQ-022 Transition RUN->STALL SHALL occur when PCwrite=0 and no branch.
REQ-023 Transition STALL->RUN SHALL occur when PCwrite=1.
REQ-024 Transition STALL->FLUSH SHALL occur on branchTaken.
REQ-025 FLUSH SHALL last exactly one cycle and then go to RUN, or to FLUSH again on another branchTaken.
REQ-026 In FLUSH, PCwrite=0 and IF_IDwrite=0 SHALL be ignored and treated as 1, so a NOP rs=x0 match cannot stall.
REQ-027 Stall counter: SHALL increment each cycle spent in STALL and clear on leaving STALL.
REQ-028 The stall counter SHALL saturate at STALL_MAX; reaching STALL_MAX SHALL set stallErr, which stays 1 until rst.
REQ-029 Latency: every input SHALL take effect at the next rising edge; the only combinational path SHALL be branchTaken->ID_EXflush.

Reset
REQ-030 On rst=1 at a clock edge, the block SHALL set PC=RESET_PC, IF_IDpc=RESET_PC, IF_IDinstr=NOP_INSTR, IF_IDvalid=0, state=RUN, stall counter=0, stallErr=0, and both performance counters=0.
REQ-031 rst asserted mid-stall or mid-flush SHALL override all other inputs in the same edge.
REQ-032 The first fetch after rst deasserts SHALL be from RESET_PC.

Configuration
REQ-033 Macro IF_ID_PERF_CNT_EN: when defined, the block SHALL add outputs stallCycles[31:0] and flushCycles[31:0].
REQ-034 With IF_ID_PERF_CNT_EN defined, the counters SHALL count cycles in STALL and FLUSH respectively, saturate at 32'hFFFFFFFF, and clear on rst.
REQ-035 With IF_ID_PERF_CNT_EN undefined, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-036 Bench SHALL cover reset: rst=1 then 0, PCwrite=IF_IDwrite=1 -> PC sequence 0,4,8; IF_IDvalid=1 from the second cycle.
REQ-037 Bench SHALL cover load-use stall: PC=0x10 with PCwrite=IF_IDwrite=0 for 1 cycle -> PC stays 0x10, IF_ID holds, state=STALL for 1 cycle, then RUN with PC=0x14.
REQ-038 Bench SHALL cover branch overriding a stall: branchTaken=1, target=0x203, PCwrite=0 -> PC=0x200, IF_IDinstr=0x00000013, IF_IDvalid=0, ID_EXflush=1 in the same cycle, state=FLUSH.
REQ-039 Bench SHALL cover the FLUSH-state stall ignore: in FLUSH with PCwrite=0 -> PC still advances by 4 and state returns to RUN.
REQ-040 Bench SHALL cover the watchdog: PCwrite=0 held 16 cycles -> stallErr=1 and it stays 1 after the stall ends; with IF_ID_PERF_CNT_EN defined, stallCycles=16.
REQ-041 Bench SHALL cover PC wrap: PC=0xFFFFFFFC with advance -> PC=0x00000000.
